// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with ready/valid handshake on both sides.
// SKID_EN=0: single entry, in_ready combinationally follows out_ready.
// SKID_EN=1: two-entry skid buffer. in_ready is registered, so there is
// no combinational path from out_ready to in_ready.
// stall_cnt counts cycles the head entry sat unaccepted and saturates at
// its maximum value.
module pipe_stage_reg #(
  parameter int DATA_W  = 81,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] main;
  logic              deliver;

  assign out_data = main;
  assign deliver  = out_valid && out_ready;

  generate
    if (SKID_EN) begin : g_skid
      localparam logic [1:0] EMPTY = 2'd0;
      localparam logic [1:0] ONE   = 2'd1;
      localparam logic [1:0] FULL  = 2'd2;

      logic [1:0]        state;
      logic [DATA_W-1:0] skid;
      logic              rdy_q;
      logic              accept;

      assign accept    = in_valid && rdy_q;
      assign in_ready  = rdy_q;
      assign out_valid = (state != EMPTY);

      // Occupancy FSM; rdy_q is kept equal to (state != FULL) as it is set
      always_ff @(posedge clk) begin
        if (reset) begin
          state <= EMPTY;
          main  <= '0;
          skid  <= '0;
          rdy_q <= 1'b1;
        end else if (flush) begin
          // payload registers keep their value, only occupancy is dropped
          state <= EMPTY;
          rdy_q <= 1'b1;
        end else begin
          case (state)
            EMPTY: begin
              if (accept) begin
                main  <= in_data;
                state <= ONE;
              end
            end
            ONE: begin
              if (accept && out_ready) begin
                main <= in_data;
              end else if (accept) begin
                skid  <= in_data;
                state <= FULL;
                rdy_q <= 1'b0;
              end else if (out_ready) begin
                state <= EMPTY;
              end
            end
            FULL: begin
              // no accept possible here since rdy_q is low
              if (out_ready) begin
                main  <= skid;
                state <= ONE;
                rdy_q <= 1'b1;
              end
            end
            default: begin
              state <= EMPTY;
              rdy_q <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_reg
      logic vld;

      assign in_ready  = !vld || out_ready;
      assign out_valid = vld;

      // Single entry: accept overwrites, deliver without refill empties
      always_ff @(posedge clk) begin
        if (reset) begin
          vld  <= 1'b0;
          main <= '0;
        end else if (flush) begin
          vld <= 1'b0;
        end else if (in_valid && in_ready) begin
          main <= in_data;
          vld  <= 1'b1;
        end else if (deliver) begin
          vld <= 1'b0;
        end
      end
    end
  endgenerate

  // Stall counter: counts blocked head cycles, saturates, clears on deliver
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stall_cnt <= '0;
    end else if (deliver) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid/CNT_W=8, skid/CNT_W=3,
// single-entry/CNT_W=8) share one stimulus stream. A queue-style model per
// instance predicts every output each cycle; literal checks pin key points.
module tb_pipe_stage_reg;
  localparam int DW = 81;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic [2:0]    ov;
  logic [2:0]    ir;
  logic [DW-1:0] od [3];
  logic [7:0]    sc0;
  logic [2:0]    sc1;
  logic [7:0]    sc2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(8)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .stall_cnt(sc0));

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .stall_cnt(sc1));

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1'b0), .CNT_W(8)) u_reg (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .stall_cnt(sc2));

  // Model: a FIFO of held entries plus the last head value seen on out_data
  logic [DW-1:0] mq [3][2];
  logic [DW-1:0] mlast [3];
  int            msz [3]  = '{0, 0, 0};
  int            mcnt [3] = '{0, 0, 0};
  int            cmax [3] = '{255, 7, 255};

  function automatic bit model_ready(input int i);
    if (i == 2) return (msz[i] == 0) || out_ready;
    return msz[i] < 2;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        msz[i] = 0; mcnt[i] = 0; mlast[i] = '0;
      end else if (flush) begin
        if (msz[i] > 0) mlast[i] = mq[i][0];
        msz[i] = 0; mcnt[i] = 0;
      end else begin
        bit acc;
        acc = in_valid && model_ready(i);
        if (msz[i] > 0 && out_ready) begin
          mlast[i] = mq[i][0];
          mq[i][0] = mq[i][1];
          msz[i]   = msz[i] - 1;
          mcnt[i]  = 0;
        end else if (msz[i] > 0 && mcnt[i] < cmax[i]) begin
          mcnt[i] = mcnt[i] + 1;
        end
        if (acc) begin
          mq[i][msz[i]] = in_data;
          msz[i] = msz[i] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [127:0] scv;
        logic [DW-1:0] eod;
        scv = (i == 0) ? 128'(sc0) : (i == 1) ? 128'(sc1) : 128'(sc2);
        eod = (msz[i] > 0) ? mq[i][0] : mlast[i];
        check($sformatf("out_valid[%0d]", i), 128'(ov[i]), 128'(msz[i] > 0));
        check($sformatf("out_data[%0d]", i), 128'(od[i]), 128'(eod));
        check($sformatf("in_ready[%0d]", i), 128'(ir[i]), 128'(model_ready(i)));
        check($sformatf("stall_cnt[%0d]", i), scv, 128'(mcnt[i]));
      end
    end
  end

  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic rst);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; reset = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [95:0] r;
    // reset state
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check("rst_out_valid", 128'(ov[0]), 128'(0));
    check("rst_out_data", 128'(od[0]), 128'(0));
    check("rst_in_ready", 128'(ir[0]), 128'(1));
    check("rst_stall_cnt", 128'(sc0), 128'(0));
    chk_en = 1'b1;

    // back-to-back streaming 1..8
    for (int k = 1; k <= 8; k++) begin
      step(1, DW'(k), 1, 0, 0);
      if (k == 1) begin
        check("b2b_first_valid", 128'(ov[0]), 128'(1));
        check("b2b_first_data", 128'(od[0]), 128'(1));
      end
    end
    check("b2b_last_data", 128'(od[0]), 128'(8));
    check("b2b_stall", 128'(sc0), 128'(0));
    step(0, '0, 1, 0, 0);

    // backpressure into FULL, then drain
    step(1, DW'('hA), 0, 0, 0);
    step(1, DW'('hB), 0, 0, 0);
    check("bp_full_in_ready", 128'(ir[0]), 128'(0));
    check("bp_stall1", 128'(sc0), 128'(1));
    check("bp_reg_in_ready", 128'(ir[2]), 128'(0));
    step(0, '0, 0, 0, 0);
    check("bp_stall2", 128'(sc0), 128'(2));
    check("bp_head_stable", 128'(od[0]), 128'('hA));
    step(0, '0, 1, 0, 0);
    check("bp_second_data", 128'(od[0]), 128'('hB));
    check("bp_stall_clear", 128'(sc0), 128'(0));
    step(0, '0, 1, 0, 0);

    // saturation: 12 blocked cycles
    step(1, DW'(5), 0, 0, 0);
    for (int k = 0; k < 12; k++) step(0, '0, 0, 0, 0);
    check("sat_cnt3", 128'(sc1), 128'(7));
    check("sat_cnt8", 128'(sc0), 128'(12));
    step(0, '0, 1, 0, 0);
    check("sat_clear", 128'(sc1), 128'(0));

    // flush while FULL with new data offered
    step(1, DW'(1), 0, 0, 0);
    step(1, DW'(2), 0, 0, 0);
    step(1, DW'('hC), 0, 1, 0);
    check("flush_out_valid", 128'(ov[0]), 128'(0));
    check("flush_in_ready", 128'(ir[0]), 128'(1));
    check("flush_stall", 128'(sc0), 128'(0));
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);

    // flush together with out_ready
    step(1, DW'(7), 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 1, 1, 0);
    check("flush_rdy_stall", 128'(sc0), 128'(0));
    check("flush_rdy_valid", 128'(ov[0]), 128'(0));

    // reset while FULL
    step(1, DW'(4), 0, 0, 0);
    step(1, DW'(5), 0, 0, 0);
    step(0, '0, 0, 0, 1);
    check("rstfull_valid", 128'(ov[0]), 128'(0));
    check("rstfull_data", 128'(od[0]), 128'(0));
    check("rstfull_in_ready", 128'(ir[0]), 128'(1));
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);

    // reset pulse between edges has no effect
    step(1, DW'('h33), 0, 0, 0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", 128'(ov[0]), 128'(1));
    check("midrst_data", 128'(od[0]), 128'('h33));
    check("midrst_stall", 128'(sc0), 128'(1));
    step(0, '0, 1, 0, 0);

    // mixed traffic
    for (int k = 0; k < 300; k++) begin
      r = {$urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), r[DW-1:0], 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 81, giving the payload width (npc 16 + cs 11 + ir 16 + address 16 + aluresult 16 + cc 3 + drid 3).
REQ-002 The block SHALL have parameter SKID_EN, default 1: 0 = single-entry register, 1 = two-entry skid buffer.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the stall counter width.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: reset, synchronous and active-high.
REQ-006 Port flush, input, 1: synchronous squash of all held entries.
REQ-007 Port in_valid, input, 1: upstream offers in_data.
REQ-008 Port in_ready, output, 1: block can accept this cycle.
REQ-009 Port in_data, input, DATA_W: upstream payload.
REQ-010 Port out_valid, output, 1: out_data is valid.
REQ-011 Port out_ready, input, 1: downstream takes out_data this cycle.
REQ-012 Port out_data, output, DATA_W: head payload.
REQ-013 Port stall_cnt, output, CNT_W: cycles the head entry was blocked.

Function
REQ-014 Accept SHALL occur when in_valid && in_ready; deliver SHALL occur when out_valid && out_ready.
REQ-015 Latency SHALL be one cycle: data accepted at edge N appears on out_data with out_valid=1 after edge N when the block was empty.
REQ-016 Entries SHALL be delivered in acceptance order, each exactly once, with no payload bit altered.
REQ-017 With SKID_EN=0, in_ready SHALL equal !out_valid || out_ready (combinational), and accept SHALL overwrite the single entry.
REQ-018 With SKID_EN=1, the block SHALL implement states EMPTY, ONE and FULL, with in_ready a registered signal equal to (state != FULL) and no combinational path from out_ready to in_ready.
REQ-019 EMPTY SHALL go to ONE on accept (main <= in_data) and otherwise stay in EMPTY.
REQ-020 ONE SHALL behave as follows:
- accept && out_ready: stay ONE, main <= in_data.
- accept && !out_ready: go to FULL, skid <= in_data.
- !accept && out_ready: go to EMPTY.
- otherwise: hold.
REQ-021 FULL SHALL go to ONE (main <= skid) on out_ready and otherwise hold, since in_ready=0.
REQ-022 out_valid SHALL be 1 exactly when state is ONE or FULL (SKID_EN=1), or when the entry is valid (SKID_EN=0); out_data SHALL always be main.
REQ-023 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready, saturate at 2^CNT_W-1 with no wrap, and clear to 0 on each deliver.
REQ-024 Flush SHALL take priority over all traffic: on the next edge state goes to EMPTY (or entry invalid), stall_cnt goes to 0, and input offered on the flush cycle is discarded.
REQ-025 Flush and out_ready asserted in the same cycle SHALL not count as a deliver for stall_cnt; stall_cnt SHALL be 0 regardless.
REQ-026 When held entries are not moving, main and skid SHALL keep their values; out_data SHALL stay stable while out_valid && !out_ready.

Reset
REQ-027 Reset SHALL give state EMPTY, out_valid=0, out_data=0, skid=0 and stall_cnt=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-028 Reset SHALL override flush and all traffic; reset mid-transfer SHALL discard every held entry.
REQ-029 Reset is synchronous only; asserting reset between edges SHALL have no effect until the next rising edge of clk.

Verification
REQ-030 Back-to-back, SKID_EN=1, out_ready=1, in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, no gaps, stall_cnt=0.
REQ-031 Backpressure: accept 0xA, then 0xB with out_ready=0 -> FULL, in_ready=0; raise out_ready -> 0xA then 0xB delivered; stall_cnt reads 1, 2, ... while blocked.
REQ-032 Saturation, CNT_W=3: hold out_ready=0 for 12 cycles with out_valid=1 -> stall_cnt stops at 7; one deliver -> 0.
REQ-033 Flush in FULL with in_valid=1 and data 0xC -> next cycle out_valid=0, in_ready=1, stall_cnt=0, and 0xC is never delivered.
REQ-034 SKID_EN=0: out_ready=0 with a held entry -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 and the new data replaces the entry.
REQ-035 Reset asserted while FULL -> next cycle out_valid=0, out_data=0, in_ready=1; held entries are never delivered.
